// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl -- instruction-fetch controller between the PC register and IF/ID.
//
// Issues one request per instruction to a variable-latency instruction memory,
// loads the IF/ID register (valid, pc, pc+4, instr) when a response arrives,
// parks a response in a one-entry hold buffer while ID is stalled, and on a
// branch/jump flush discards whatever is in flight or held.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pc_in             current PC (PC register output)
//   pc_en             PC register write enable (combinational, 0 during rst)
//   imem_req          request to instruction memory (high in S_WAIT / S_DRAIN)
//   imem_addr         registered fetch address, stable while imem_req=1
//   imem_ready        one-cycle response strobe, imem_rdata valid with it
//   imem_rdata        fetched instruction word
//   stall_id          ID cannot accept a new instruction
//   flush             branch/jump taken; redirect target is loaded into the PC
//   if_id_valid/pc/pc4/instr  IF/ID pipeline register
//   perf_fetch_cnt    instructions delivered to IF/ID
//   perf_stall_cnt    cycles spent in S_WAIT or S_HOLD
//
// Build option: define IF_FETCH_PERF_CNT_EN to enable the two performance
// counters; otherwise both perf outputs are tied to zero.

module if_fetch_ctrl #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        flush,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic [31:0] if_id_instr,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        pc_en_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_ISSUE;
      imem_addr_q  <= '0;
      valid_q      <= 1'b0;
      pc_q         <= '0;
      pc4_q        <= '0;
      instr_q      <= NOP_INSTR;
      hold_pc_q    <= '0;
      hold_instr_q <= '0;
    end else begin
      state_q      <= state_d;
      imem_addr_q  <= imem_addr_d;
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    imem_addr_d  = imem_addr_q;
    valid_d      = valid_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    pc_en_c      = 1'b0;

    case (state_q)
      S_ISSUE: begin
        imem_addr_d = pc_in;
        state_d     = flush ? S_ISSUE : S_WAIT;
      end
      S_WAIT: begin
        if (flush) begin
          // A response still outstanding must be drained before reissuing.
          state_d = imem_ready ? S_ISSUE : S_DRAIN;
        end else if (imem_ready) begin
          if (stall_id) begin
            hold_pc_d    = imem_addr_q;
            hold_instr_d = imem_rdata;
            state_d      = S_HOLD;
          end else begin
            valid_d = 1'b1;
            pc_d    = imem_addr_q;
            pc4_d   = imem_addr_q + 32'd4;
            instr_d = imem_rdata;
            pc_en_c = 1'b1;
            state_d = S_ISSUE;
          end
        end
      end
      S_HOLD: begin
        if (flush) begin
          state_d = S_ISSUE;
        end else if (!stall_id) begin
          valid_d = 1'b1;
          pc_d    = hold_pc_q;
          pc4_d   = hold_pc_q + 32'd4;
          instr_d = hold_instr_q;
          pc_en_c = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (!flush && imem_ready) state_d = S_ISSUE;
      end
      default: state_d = S_ISSUE;
    endcase

    // Flush overrides whatever the state logic chose for IF/ID and pc_en.
    if (flush) begin
      pc_en_c = 1'b1;
      valid_d = 1'b0;
      pc_d    = '0;
      pc4_d   = '0;
      instr_d = NOP_INSTR;
    end
  end

  assign pc_en       = pc_en_c & ~rst;
  assign imem_req    = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign imem_addr   = imem_addr_q;
  assign if_id_valid = valid_q;
  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    // A non-flush pc_en is exactly an IF/ID load with valid=1.
    if (pc_en_c && !flush) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (state_q == S_WAIT || state_q == S_HOLD) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Testbench for if_fetch_ctrl: directed vector table, a pc+4 wrap / perf
// counter sequence, and randomized traffic against a transaction-level model.

module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        flush;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic [31:0] if_id_instr;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_en(pc_en),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall_id(stall_id), .flush(flush),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_instr(if_id_instr),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          chk;
    bit          rst;
    logic [31:0] pc;
    bit          rdy;
    logic [31:0] rdata;
    bit          stall;
    bit          flush;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_pcen;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit r, logic [31:0] p, bit rd, logic [31:0] rv, bit s, bit f,
                              bit eq, logic [31:0] ea, bit ep, bit ev, logic [31:0] epc,
                              logic [31:0] ep4, logic [31:0] ei);
    vec_t v;
    v.chk = c; v.rst = r; v.pc = p; v.rdy = rd; v.rdata = rv; v.stall = s; v.flush = f;
    v.e_req = eq; v.e_addr = ea; v.e_pcen = ep; v.e_valid = ev;
    v.e_pc = epc; v.e_pc4 = ep4; v.e_instr = ei;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // Transaction view: a request is in flight, possibly marked for discard,
  // or a response is parked; none of these means the next fetch is issued.
  bit          m_out, m_drop, m_held, m_valid;
  logic [31:0] m_addr, m_hpc, m_hinstr, m_pc, m_pc4, m_instr;
  logic [31:0] m_fcnt, m_scnt;
  int          m_dlv;
  logic [31:0] pc_reg;
  bit          busy;
  int          cnt;
  int          lat_max, p_stall, p_flush;
  bit          spur;

  task automatic model_reset();
    m_out = 0; m_drop = 0; m_held = 0; m_valid = 0;
    m_addr = '0; m_hpc = '0; m_hinstr = '0;
    m_pc = '0; m_pc4 = '0; m_instr = '0;
    m_fcnt = '0; m_scnt = '0; m_dlv = 0;
    pc_reg = '0; busy = 0; cnt = 0;
  endtask

  task automatic cyc(input bit r, input bit do_chk);
    bit st, fl, rd, e_pcen, ld;
    logic [31:0] rdv, tgt, lpc, linstr;
    @(negedge clk);
    if (do_chk) begin
      chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("pc", if_id_pc, m_pc);
      chk("pc4", if_id_pc4, m_pc4);
      chk("instr", if_id_instr, m_instr);
`ifdef IF_FETCH_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fcnt);
      chk("perf_stall", perf_stall_cnt, m_scnt);
`else
      chk("perf_fetch", perf_fetch_cnt, 32'h0);
      chk("perf_stall", perf_stall_cnt, 32'h0);
`endif
    end
    st  = ($urandom % 100) < p_stall;
    fl  = ($urandom % 100) < p_flush;
    tgt = $urandom & 32'hFFFF_FFFC;
    rdv = $urandom;
    rd  = 0;
    // Memory: one strobe per request, 1..lat_max cycles after it rises.
    if (r) begin
      busy = 0;
    end else if (busy) begin
      cnt--;
      if (cnt == 0) begin rd = 1; busy = 0; end
    end else if (m_out) begin
      busy = 1;
      cnt  = 1 + ($urandom % lat_max);
    end else if (spur) begin
      rd = ($urandom % 4) == 0;
    end
    rst = r; pc_in = pc_reg; stall_id = st; flush = fl;
    imem_ready = rd; imem_rdata = rdv;
    #1;
    e_pcen = !r && (fl || (!st && (m_held || (m_out && !m_drop && rd))));
    if (do_chk) begin
      chk("pc_en", {31'b0, pc_en}, {31'b0, e_pcen});
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_out});
      if (m_out) chk("imem_addr", imem_addr, m_addr);
    end
    if (r) begin
      model_reset();
    end else begin
      if ((m_out && !m_drop) || m_held) m_scnt++;
      ld = 0; lpc = '0; linstr = '0;
      if (fl) begin
        m_held = 0;
        if (m_out && !m_drop) begin
          if (rd) m_out = 0; else m_drop = 1;
        end
        m_valid = 0; m_pc = '0; m_pc4 = '0; m_instr = '0;
      end else if (!m_out && !m_held) begin
        m_addr = pc_reg; m_out = 1;
      end else if (m_held) begin
        if (!st) begin ld = 1; lpc = m_hpc; linstr = m_hinstr; m_held = 0; end
      end else if (rd) begin
        m_out = 0;
        if (m_drop) m_drop = 0;
        else if (st) begin m_held = 1; m_hpc = m_addr; m_hinstr = rdv; end
        else begin ld = 1; lpc = m_addr; linstr = rdv; end
      end
      if (ld) begin
        m_valid = 1; m_pc = lpc; m_pc4 = lpc + 32'd4; m_instr = linstr;
        m_fcnt++; m_dlv++;
      end
      if (e_pcen) pc_reg = fl ? tgt : pc_reg + 32'd4;
    end
  endtask

  initial begin
    int guard;
    rst = 1; pc_in = '0; imem_ready = 0; imem_rdata = '0; stall_id = 0; flush = 0;

    //        chk rst pc   rdy rdata          st fl | req addr pcen val pc   pc4  instr
    tbl.push_back(mk(0,1,'h00,0,'h0,         0,0,  0,'h00,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,1,'h00,0,'h0,         0,0,  0,'h00,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h00,0,'h0,         0,0,  0,'h00,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h00,0,'h0,         0,0,  1,'h00,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h00,1,'h2008_0005, 0,0,  1,'h00,1,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h04,0,'h0,         0,0,  0,'h00,0,1,'h00,'h04,'h2008_0005));
    tbl.push_back(mk(1,0,'h04,1,'hAAAA_0001, 1,0,  1,'h04,0,1,'h00,'h04,'h2008_0005));
    tbl.push_back(mk(1,0,'h04,0,'h0,         1,0,  0,'h00,0,1,'h00,'h04,'h2008_0005));
    tbl.push_back(mk(1,0,'h04,0,'h0,         1,0,  0,'h00,0,1,'h00,'h04,'h2008_0005));
    tbl.push_back(mk(1,0,'h04,0,'h0,         0,0,  0,'h00,1,1,'h00,'h04,'h2008_0005));
    tbl.push_back(mk(1,0,'h08,0,'h0,         0,0,  0,'h00,0,1,'h04,'h08,'hAAAA_0001));
    tbl.push_back(mk(1,0,'h08,1,'hBBBB_0002, 1,0,  1,'h08,0,1,'h04,'h08,'hAAAA_0001));
    tbl.push_back(mk(1,0,'h08,0,'h0,         1,1,  0,'h00,1,1,'h04,'h08,'hAAAA_0001));
    tbl.push_back(mk(1,0,'h40,0,'h0,         0,0,  0,'h00,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h40,1,'hCCCC_0003, 0,0,  1,'h40,1,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h44,0,'h0,         0,0,  0,'h00,0,1,'h40,'h44,'hCCCC_0003));
    tbl.push_back(mk(1,0,'h44,0,'h0,         0,1,  1,'h44,1,1,'h40,'h44,'hCCCC_0003));
    tbl.push_back(mk(1,0,'h80,0,'h0,         0,0,  1,'h44,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h80,1,'hDEAD_BEEF, 0,0,  1,'h44,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h80,0,'h0,         0,0,  0,'h00,0,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h80,1,'h1111_1111, 0,0,  1,'h80,1,0,'h00,'h00,'h0));
    tbl.push_back(mk(1,0,'h84,0,'h0,         0,0,  0,'h00,0,1,'h80,'h84,'h1111_1111));
    tbl.push_back(mk(1,1,'h84,1,'h9999_9999, 0,1,  1,'h84,0,1,'h80,'h84,'h1111_1111));
    tbl.push_back(mk(1,0,'h00,0,'h0,         0,0,  0,'h00,0,0,'h00,'h00,'h0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; pc_in = tbl[i].pc; imem_ready = tbl[i].rdy;
      imem_rdata = tbl[i].rdata; stall_id = tbl[i].stall; flush = tbl[i].flush;
      #1;
      if (tbl[i].chk) begin
        chk($sformatf("t%0d_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
        if (tbl[i].e_req) chk($sformatf("t%0d_addr", i), imem_addr, tbl[i].e_addr);
        chk($sformatf("t%0d_pc_en", i), {31'b0, pc_en}, {31'b0, tbl[i].e_pcen});
        chk($sformatf("t%0d_valid", i), {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
        chk($sformatf("t%0d_pc", i), if_id_pc, tbl[i].e_pc);
        chk($sformatf("t%0d_pc4", i), if_id_pc4, tbl[i].e_pc4);
        chk($sformatf("t%0d_instr", i), if_id_instr, tbl[i].e_instr);
      end
    end

    // pc+4 wrap and counter sequence: latency 1, no stalls or flushes.
    model_reset();
    lat_max = 1; p_stall = 0; p_flush = 0; spur = 0;
    cyc(1, 0);
    cyc(1, 1);
    pc_reg = 32'hFFFF_FFFC;
    guard = 0;
    while (m_dlv < 1 && guard < 20) begin cyc(0, 1); guard++; end
    if (m_dlv < 1) chk("wrap_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    chk("wrap_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_id_pc4, 32'h0000_0000);
    guard = 0;
    while (m_dlv < 5 && guard < 40) begin cyc(0, 1); guard++; end
    if (m_dlv < 5) chk("five_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
`ifdef IF_FETCH_PERF_CNT_EN
    chk("five_fetch_cnt", perf_fetch_cnt, 32'd5);
    chk("five_stall_cnt", perf_stall_cnt, 32'd10);
`else
    chk("five_fetch_cnt", perf_fetch_cnt, 32'd0);
    chk("five_stall_cnt", perf_stall_cnt, 32'd0);
`endif

    // Randomized traffic with stalls, flushes, stray strobes and resets.
    lat_max = 4; p_stall = 30; p_flush = 8; spur = 1;
    for (int i = 0; i < 3000; i++) cyc(($urandom % 200) == 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
